// File: rtl/serial_addsub_seq_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer.
// Optional signed-overflow output is enabled with SERIAL_ADDSUB_OVF_EN.
package serial_addsub_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_seq_if.sv
// Request/response bundle of the serial add/subtract sequencer.
// The ovf signal exists only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, op_sub, a, b,
`ifdef SERIAL_ADDSUB_OVF_EN
    input  busy, done, result, carry_out, ovf
`else
    input  busy, done, result, carry_out
`endif
  );

  modport slave (
    input  start, op_sub, a, b,
`ifdef SERIAL_ADDSUB_OVF_EN
    output busy, done, result, carry_out, ovf
`else
    output busy, done, result, carry_out
`endif
  );
endinterface

// File: rtl/FULL_ADDER.sv
// Gate-level one-bit full adder cell shared by the serial datapath.
module FULL_ADDER (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);
  logic axb, gen, prop;

  xor u_x0 (axb, a, b);
  xor u_x1 (s, axb, cin);
  and u_a0 (gen, a, b);
  and u_a1 (prop, axb, cin);
  or  u_o0 (c, gen, prop);
endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract: one full-adder cell, LSB first, WIDTH cycles per op.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output.
module serial_addsub_seq
  import serial_addsub_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  serial_addsub_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt, result_q;
  logic [CNT_W-1:0] cnt;
  logic             cy, carry_q;
  logic             s, co;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             msb_cin;
`endif

  FULL_ADDER u_full_adder (
    .s   (s),
    .c   (co),
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (cy)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
  assign sum_nxt = {s, {(WIDTH-1){1'b0}}} | (sum_sr >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      cnt      <= '0;
      cy       <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      msb_cin  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= (bus.op_sub == OP_ADD) ? bus.b : ~bus.b;
            cy    <= (bus.op_sub == OP_SUB);
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_sr <= sum_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cy     <= co;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            result_q <= sum_nxt;
            carry_q  <= co;
`ifdef SERIAL_ADDSUB_OVF_EN
            msb_cin  <= cy;
`endif
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == ST_RUN) || (state == ST_DONE);
  assign bus.done      = (state == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  // Both terms are captured on the final-bit edge, so ovf holds with result.
  assign bus.ovf       = msb_cin ^ carry_q;
`endif

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed bench for serial_addsub_seq (WIDTH=32); ovf checks need SERIAL_ADDSUB_OVF_EN.
module tb_serial_addsub_seq;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  serial_addsub_seq_if #(.WIDTH(W)) bus ();

  serial_addsub_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, scramble operands mid-run, check timing and result.
  task automatic do_op(input string tag, input logic sub, input logic [31:0] av, bv,
                       input logic [31:0] exp_r, input logic exp_c, input logic exp_o);
    bus.start  = 1'b1;
    bus.op_sub = sub;
    bus.a      = av;
    bus.b      = bv;
    tick();
    bus.start  = 1'b0;
    bus.a      = ~av;
    bus.b      = ~bv;
    bus.op_sub = ~sub;
    for (int c = 1; c <= W; c++) begin
      check({tag, "_run_busy_done"}, {30'd0, bus.busy, bus.done}, 32'd2);
      tick();
    end
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_result"}, bus.result, exp_r);
    check({tag, "_carry"}, {31'd0, bus.carry_out}, {31'd0, exp_c});
`ifdef SERIAL_ADDSUB_OVF_EN
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
`else
    if (exp_o) begin end
`endif
    tick();
    check({tag, "_idle_busy_done"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({tag, "_result_held"}, bus.result, exp_r);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    tick(2);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_carry", {31'd0, bus.carry_out}, 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif

    // reset wins over a coincident start
    bus.start = 1'b1;
    bus.a     = 32'd9;
    tick();
    check("rst_prio_busy", {31'd0, bus.busy}, 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    check("idle_no_start", {31'd0, bus.busy}, 32'd0);

    do_op("add_5_7",   1'b0, 32'd5,          32'd7,  32'd12,         1'b0, 1'b0);
    do_op("add_wrap",  1'b0, 32'hFFFF_FFFF,  32'd1,  32'd0,          1'b1, 1'b0);
    do_op("sub_3_5",   1'b1, 32'd3,          32'd5,  32'hFFFF_FFFE,  1'b0, 1'b0);
    do_op("sub_5_3",   1'b1, 32'd5,          32'd3,  32'd2,          1'b1, 1'b0);
    do_op("add_ovf",   1'b0, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000,  1'b0, 1'b1);
    do_op("sub_ovf",   1'b1, 32'h8000_0000,  32'd1,  32'h7FFF_FFFF,  1'b1, 1'b1);

    // start held high: accepted only in IDLE, operands sampled only then
    bus.start  = 1'b1;
    bus.op_sub = 1'b0;
    bus.a      = 32'd10;
    bus.b      = 32'd20;
    tick();
    check("hold_busy_c1", {31'd0, bus.busy}, 32'd1);
    tick(9);
    bus.a = 32'd100;
    bus.b = 32'd1;
    for (int c = 10; c <= W; c++) begin
      check("hold_no_done", {31'd0, bus.done}, 32'd0);
      tick();
    end
    check("hold_done1", {31'd0, bus.done}, 32'd1);
    check("hold_result1", bus.result, 32'd30);
    tick();
    check("hold_idle", {30'd0, bus.busy, bus.done}, 32'd0);
    tick();
    check("hold_reaccept", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    tick(W);
    check("hold_done2", {31'd0, bus.done}, 32'd1);
    check("hold_result2", bus.result, 32'd101);
    tick();

    // reset in RUN cycle 10 aborts without a done pulse and clears result
    bus.start = 1'b1;
    bus.a     = 32'h1234;
    bus.b     = 32'h1;
    tick();
    bus.start = 1'b0;
    tick(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    for (int c = 0; c < 30; c++) begin
      check("abort_quiet", {30'd0, bus.busy, bus.done}, 32'd0);
      tick();
    end
    do_op("after_rst", 1'b1, 32'd5, 32'd3, 32'd2, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_addsub_seq.md
# serial_addsub_seq

Bit-serial add/subtract sequencer that time-shares a single one-bit full-adder cell across a WIDTH-bit operation, LSB first, one bit per clock. It is the area-minimal arithmetic path for the processor's multi-cycle operations. It accepts a start pulse with latched operands, runs WIDTH shift cycles, then reports the result with a one-cycle done pulse.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  reset; synchronous and active-high
- start  in  1  request; sampled only in IDLE
- op_sub  in  1  0 = a+b, 1 = a−b; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse in DONE
- result  out  WIDTH  last completed sum/difference; held until the next completion
- carry_out  out  1  final carry; for subtract, 1 = no borrow (a ≥ b unsigned)
- ovf  out  1  signed overflow; present only with SERIAL_ADDSUB_OVF_EN

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE, start=1:
  - a_sr ← a
  - b_sr ← op_sub ? ~b : b
  - cy ← op_sub
  - cnt ← 0
  - next state RUN
- IDLE, start=0: remain in IDLE.
- RUN, every cycle:
  - Full adder computes s, co from a_sr[0], b_sr[0], cy.
  - sum_sr ← {s, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one.
  - cy ← co.
  - cnt ← cnt+1.
- RUN, cycle with cnt = WIDTH−1 (final bit):
  - result ← {s, sum_sr[WIDTH-1:1]}
  - carry_out ← co
  - msb_cin ← cy, the carry into the MSB
  - next state DONE
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start in RUN or DONE is ignored. It is not queued.
- Arithmetic is modulo 2^WIDTH. Counter width is clog2(WIDTH). Subtract is two's-complement: b inverted, carry-in 1.

## Timing
- Reset values:
  - state IDLE
  - busy 0, done 0
  - result 0, carry_out 0, ovf 0
  - internal shift registers, cy and cnt all 0
- rst has priority over everything, including start on the same edge.
- rst during RUN or DONE: IDLE at the next edge. No done pulse; result is cleared to 0.
- Latency: start sampled at edge 0 → RUN for cycles 1..WIDTH → done=1 and result valid in cycle WIDTH+1.
- busy rises the cycle after start is accepted. It falls the cycle after done.
- The earliest next start is accepted in the cycle after done, which is the IDLE cycle. Issue interval is WIDTH+2 cycles.
- result, carry_out and ovf update only on the final-bit edge. They are stable in DONE and in IDLE afterwards.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - ovf port exists.
  - ovf ← msb_cin ^ co, updated on the final-bit edge.
  - ovf is reset to 0.
- Not defined:
  - No ovf port, no msb_cin register.
  - All other behaviour is identical.

## Structure
- Shared package/header holds:
  - State encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - Op encoding: OP_ADD=1'b0, OP_SUB=1'b1
- Single sub-module: one instance of the team's existing gate-level FULL_ADDER cell, ports s, c, a, b, cin. No other arithmetic is inferred in the datapath.
- State encoding 2'd3 is illegal and recovers to IDLE on the next edge.

## Test plan
All scenarios use WIDTH=32.

1. add 5+7, start at edge 0 → done=1 in cycle 33, result=12, carry_out=0, busy high in cycles 1..33.
2. add 0xFFFFFFFF+1 → result=0, carry_out=1, ovf=0.
3. sub 3−5 → result=0xFFFFFFFE, carry_out=0. Then sub 5−3 → result=2, carry_out=1.
4. With macro defined:
   - add 0x7FFFFFFF+1 → result 0x80000000, ovf=1.
   - sub 0x80000000−1 → result 0x7FFFFFFF, ovf=1.
   - Without the macro the bench compiles with no ovf port.
5. start held high throughout → operations accepted only in IDLE cycles, every 34 cycles. Operands changed mid-RUN do not affect result.
6. rst asserted in RUN cycle 10 → busy=0 and result=0 next cycle. No done pulse. A new start after rst completes normally.
